// File: rtl/shli_pipelined_pkg.sv
// Shared helpers for the pipelined left shifter: shift-amount width and
// stage partitioning derived from BITWIDTH / STAGE_BITS.
package shli_pipelined_pkg;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        for (int x = value - 1; x > 0; x = x >> 1) begin
            result++;
        end
        return result;
    endfunction

    function automatic int num_stages(input int shamt_w, input int stage_bits);
        return (shamt_w + stage_bits - 1) / stage_bits;
    endfunction

    // Upper (exclusive) shift-amount bit index handled by stage k.
    function automatic int stage_hi(input int k, input int stage_bits, input int shamt_w);
        return ((k + 1) * stage_bits < shamt_w) ? (k + 1) * stage_bits : shamt_w;
    endfunction

endpackage

// File: rtl/shli_pipelined_stage.sv
// One registered shift stage: applies the shifts 2^LO .. 2^(HI-1) selected by
// the carried shift amount, with a valid/ready register slice.
module shli_stage
    import shli_pipelined_pkg::*;
#(
    parameter int BITWIDTH = 32,
    parameter int SHAMT_W  = 5,
    parameter int LO       = 0,
    parameter int HI       = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BITWIDTH-1:0] in_data,
    input  logic [SHAMT_W-1:0]  in_shamt,
    input  logic                in_zero,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [BITWIDTH-1:0] out_data,
    output logic [SHAMT_W-1:0]  out_shamt,
    output logic                out_zero
);

    logic [BITWIDTH-1:0] shifted;

    always_comb begin
        shifted = in_data;
        for (int j = LO; j < HI; j++) begin
            if (in_shamt[j]) begin
                shifted = shifted << (1 << j);
            end
        end
    end

    // The slice can take a new token when empty or when its token leaves now.
    assign in_ready = ~out_valid | out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_shamt <= '0;
            out_zero  <= 1'b0;
        end else if (in_ready) begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_data  <= shifted;
                out_shamt <= in_shamt;
                out_zero  <= in_zero;
            end
        end
    end

endmodule

// File: rtl/shli_pipelined.sv
// Elastic pipelined logical shift-left: result = lhs << rhs, zero when rhs >= BITWIDTH.
// lhs and rhs are joined and pass through NUM_STAGES registered shift stages.
module shli_pipelined
    import shli_pipelined_pkg::*;
#(
    parameter int BITWIDTH   = 32,
    parameter int STAGE_BITS = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [BITWIDTH-1:0] lhs,
    input  logic                lhs_valid,
    output logic                lhs_ready,
    input  logic [BITWIDTH-1:0] rhs,
    input  logic                rhs_valid,
    output logic                rhs_ready,
    output logic [BITWIDTH-1:0] result,
    output logic                result_valid,
    input  logic                result_ready
);

    localparam int SHAMT_W    = clog2(BITWIDTH);
    localparam int NUM_STAGES = num_stages(SHAMT_W, STAGE_BITS);
    localparam logic [BITWIDTH-1:0] BW_VALUE = BITWIDTH;

    // Handshake: a token moves across a boundary in a cycle where valid & ready
    // are both high; valid never depends on ready, ready flows combinationally
    // upstream, and a held token keeps valid high and data stable.
    logic                valid_s [NUM_STAGES+1];
    logic                ready_s [NUM_STAGES+1];
    logic [BITWIDTH-1:0] data_s  [NUM_STAGES+1];
    logic [SHAMT_W-1:0]  shamt_s [NUM_STAGES+1];
    logic                zero_s  [NUM_STAGES+1];

    // Two-input join: both operands are taken together or not at all.
    assign lhs_ready  = rhs_valid & ready_s[0] & ~rst;
    assign rhs_ready  = lhs_valid & ready_s[0] & ~rst;
    assign valid_s[0] = lhs_valid & rhs_valid & ~rst;
    assign data_s[0]  = lhs;
    assign shamt_s[0] = rhs[SHAMT_W-1:0];
    assign zero_s[0]  = (rhs >= BW_VALUE);

    for (genvar k = 0; k < NUM_STAGES; k++) begin : g_stage
        shli_stage #(
            .BITWIDTH (BITWIDTH),
            .SHAMT_W  (SHAMT_W),
            .LO       (k * STAGE_BITS),
            .HI       (stage_hi(k, STAGE_BITS, SHAMT_W))
        ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .in_valid  (valid_s[k]),
            .in_ready  (ready_s[k]),
            .in_data   (data_s[k]),
            .in_shamt  (shamt_s[k]),
            .in_zero   (zero_s[k]),
            .out_valid (valid_s[k+1]),
            .out_ready (ready_s[k+1]),
            .out_data  (data_s[k+1]),
            .out_shamt (shamt_s[k+1]),
            .out_zero  (zero_s[k+1])
        );
    end

    assign ready_s[NUM_STAGES] = result_ready;
    assign result_valid        = valid_s[NUM_STAGES] & ~rst;
    assign result              = zero_s[NUM_STAGES] ? '0 : data_s[NUM_STAGES];

endmodule

// File: tb/tb_shli_pipelined.sv
// Bench for shli_pipelined (BITWIDTH=32, STAGE_BITS=2): vector table, latency,
// stream, stall, join, reset and random-stall scoreboard runs.
module tb_shli_pipelined;

    logic        clk;
    logic        rst;
    logic [31:0] lhs;
    logic        lhs_valid;
    logic        lhs_ready;
    logic [31:0] rhs;
    logic        rhs_valid;
    logic        rhs_ready;
    logic [31:0] result;
    logic        result_valid;
    logic        result_ready;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bit rand_stall = 0;
    logic [31:0] exp_q[$];
    int          out_cyc[$];

    typedef struct {
        logic [31:0] lhs;
        logic [31:0] rhs;
        logic [31:0] exp;
    } vec_t;
    vec_t vecs[11];

    shli_pipelined #(.BITWIDTH(32), .STAGE_BITS(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .lhs          (lhs),
        .lhs_valid    (lhs_valid),
        .lhs_ready    (lhs_ready),
        .rhs          (rhs),
        .rhs_valid    (rhs_valid),
        .rhs_ready    (rhs_ready),
        .result       (result),
        .result_valid (result_valid),
        .result_ready (result_ready)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard helpers ----------------
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b);
        if (b >= 32) return 32'h0;
        return a << b[4:0];
    endfunction

    always @(negedge clk) begin
        if (result_valid && result_ready) begin
            out_cyc.push_back(cyc);
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_output: got %h, expected no token", result);
            end else begin
                chk("result", result, exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_stall) result_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    // Called at posedge+1; returns at posedge+1 just after the handshake edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b);
        int waited;
        bit ok;
        waited = 0;
        ok = 1;
        lhs = a;
        rhs = b;
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        @(negedge clk);
        while (!(lhs_ready && rhs_ready)) begin
            if (waited == 1000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got no handshake, expected one within 1000 cycles");
                ok = 0;
                break;
            end
            waited++;
            @(negedge clk);
        end
        if (ok) exp_q.push_back(model(a, b));
        @(posedge clk);
        #1;
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("drain_empty", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    initial begin
        int lat;
        int n0;
        logic [31:0] held;

        vecs[0]  = '{32'h0000_00F1, 32'd4,          32'h0000_0F10};
        vecs[1]  = '{32'h0000_0001, 32'd32,         32'h0000_0000};
        vecs[2]  = '{32'h0000_0001, 32'h8000_0001,  32'h0000_0000};
        vecs[3]  = '{32'h0000_0003, 32'd31,         32'h8000_0000};
        vecs[4]  = '{32'hDEAD_BEEF, 32'd0,          32'hDEAD_BEEF};
        vecs[5]  = '{32'hFFFF_FFFF, 32'd16,         32'hFFFF_0000};
        vecs[6]  = '{32'h1234_5678, 32'd8,          32'h3456_7800};
        vecs[7]  = '{32'h8000_0001, 32'd1,          32'h0000_0002};
        vecs[8]  = '{32'hA5A5_A5A5, 32'd33,         32'h0000_0000};
        vecs[9]  = '{32'h0000_FFFF, 32'd20,         32'hFFF0_0000};
        vecs[10] = '{32'h0000_0001, 32'hFFFF_FFFF,  32'h0000_0000};

        rst = 1'b1;
        lhs = '0;
        rhs = '0;
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        result_ready = 1'b1;
        @(negedge clk);
        chk("rst_lhs_ready", {31'b0, lhs_ready}, 32'd0);
        chk("rst_rhs_ready", {31'b0, rhs_ready}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        @(negedge clk);
        chk("reset_result_valid", {31'b0, result_valid}, 32'd0);
        chk("reset_result", result, 32'd0);
        @(posedge clk);
        #1;

        // Latency of a single token with an always-ready consumer.
        lhs = 32'h0000_00F1;
        rhs = 32'd4;
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        @(negedge clk);
        chk("lat_handshake", {31'b0, lhs_ready & rhs_ready}, 32'd1);
        exp_q.push_back(32'h0000_0F10);
        @(posedge clk);
        #1;
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        lat = 0;
        while (lat < 20) begin
            @(negedge clk);
            lat++;
            if (result_valid) break;
        end
        chk("latency", lat, 32'd3);
        drain();

        // Vector table, issued back to back.
        for (int i = 0; i < 11; i++) send(vecs[i].lhs, vecs[i].rhs);
        for (int i = 0; i < 11; i++) chk("vec_model", model(vecs[i].lhs, vecs[i].rhs), vecs[i].exp);
        drain();

        // Ten-token stream: one result per cycle, no bubbles.
        n0 = out_cyc.size();
        for (int i = 0; i < 10; i++) send(32'd1, i);
        drain();
        chk("stream_count", out_cyc.size() - n0, 32'd10);
        if (out_cyc.size() >= n0 + 10) chk("stream_no_bubble", out_cyc[n0 + 9] - out_cyc[n0], 32'd9);

        // Fill pipe with consumer stalled, hold 5 cycles, then release.
        result_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'h0000_0005 + i, 4 * i + 1);
        lhs = 32'h0000_0077;
        rhs = 32'd2;
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        @(negedge clk);
        held = result;
        chk("stall_valid_first", {31'b0, result_valid}, 32'd1);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", {31'b0, result_valid}, 32'd1);
            chk("stall_result", result, held);
            chk("stall_no_accept", {31'b0, lhs_ready}, 32'd0);
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        send(32'h0000_0077, 32'd2);
        drain();

        // Join: lhs alone is never taken.
        lhs = 32'h0000_0009;
        rhs = 32'd3;
        lhs_valid = 1'b1;
        rhs_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("join_lhs_ready", {31'b0, lhs_ready}, 32'd0);
            @(posedge clk);
            #1;
        end
        n0 = out_cyc.size();
        idle(4);
        chk("join_nothing_entered", out_cyc.size() - n0, 32'd0);
        send(32'h0000_0009, 32'd3);
        drain();
        chk("join_single_token", out_cyc.size() - n0, 32'd1);

        // Reset with three tokens in flight.
        result_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(32'hFFFF_0000 + i, i);
        lhs_valid = 1'b1;
        rhs_valid = 1'b1;
        rst = 1'b1;
        exp_q.delete();
        @(negedge clk);
        chk("midrst_lhs_ready", {31'b0, lhs_ready}, 32'd0);
        chk("midrst_result_valid", {31'b0, result_valid}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        lhs_valid = 1'b0;
        rhs_valid = 1'b0;
        @(negedge clk);
        chk("postrst_result_valid", {31'b0, result_valid}, 32'd0);
        chk("postrst_result", result, 32'd0);
        result_ready = 1'b1;
        n0 = out_cyc.size();
        idle(10);
        chk("postrst_no_stale", out_cyc.size() - n0, 32'd0);

        // Random stalls, gaps and shift amounts.
        rand_stall = 1;
        for (int i = 0; i < 10000; i++) begin
            logic [31:0] a;
            logic [31:0] b;
            a = $urandom;
            b = ($urandom_range(0, 9) == 0) ? $urandom : $urandom_range(0, 40);
            if ($urandom_range(0, 4) == 0) idle(1);
            send(a, b);
        end
        rand_stall = 0;
        @(posedge clk);
        #1;
        result_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
